uart_core: RTL and testbench

Parametrised full-duplex UART for the serial link: one TX channel with a valid/ready input handshake and one RX channel with a valid/ready output handshake. Data width, parity mode, stop-bit count and bit period are all parameters. Over a single-byte UART it adds three things: an RX output that stalls under back-pressure, per-frame parity/framing error flags, and an optional RX FIFO. It sits between the host logic and the `rx`/`tx` pins.

---
 rtl/uart_core.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with valid/ready on both channels.
// Define UART_RX_FIFO_EN to replace the RX holding register with a FIFO_DEPTH-entry FIFO.
module uart_core #(
  parameter int unsigned DIV        = 2604,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 2,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] t_data,
  input  logic                 t_valid,
  output logic                 t_ready,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic                 r_perr,
  output logic                 r_ferr,
  output logic                 r_overrun
);
  localparam int unsigned   CW        = $clog2(DIV);
  localparam logic [CW-1:0] CNT_BIT   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);

  if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || STOP_BITS < 1 ||
      STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_core: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  state_e               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;

  // Stop phase reuses the bit counter so STOP_BITS x DIV fits in a CW-bit timer.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q == S_IDLE) begin
      if (t_valid) begin
        tx_state_d = S_START;
        tx_cnt_d   = CNT_BIT;
        tx_sh_d    = t_data;
        tx_par_d   = par_of(t_data);
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end else begin
      tx_cnt_d = CNT_BIT;
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_bit_d   = BIT_LAST;
        end
        S_DATA: begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q != '0) begin
            tx_bit_d = tx_bit_q - 1'b1;
          end else if (HAS_PAR) begin
            tx_state_d = S_PARITY;
          end else begin
            tx_state_d = S_STOP;
            tx_bit_d   = STOP_LAST;
          end
        end
        S_PARITY: begin
          tx_state_d = S_STOP;
          tx_bit_d   = STOP_LAST;
        end
        S_STOP: begin
          if (tx_bit_q != '0) tx_bit_d = tx_bit_q - 1'b1;
          else                tx_state_d = S_IDLE;
        end
        default: tx_state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = tx_sh_q[0];
      S_PARITY: tx = tx_par_q;
      default:  tx = 1'b1;
    endcase
  end

  assign t_ready = (tx_state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
    end
  end

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_e               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic                 frame_done, frame_perr, frame_ferr;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    frame_done = 1'b0;
    if (rx_state_q == S_IDLE) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = CNT_HALF;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      rx_cnt_d = CNT_BIT;
      case (rx_state_q)
        S_START: begin
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = BIT_LAST;
          end
        end
        S_DATA: begin
          rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q != '0)  rx_bit_d   = rx_bit_q - 1'b1;
          else if (HAS_PAR)    rx_state_d = S_PARITY;
          else                 rx_state_d = S_STOP;
        end
        S_PARITY: begin
          rx_par_d   = rx_s2_q;
          rx_state_d = S_STOP;
        end
        S_STOP: begin
          frame_done = 1'b1;
          rx_state_d = S_IDLE;
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  assign frame_ferr = !rx_s2_q;
  assign frame_perr = HAS_PAR && (rx_par_q != par_of(rx_sh_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_BITS + 2;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          empty, full, push, pop;
  logic          ovr_q, ovr_d;

  // A pop on the completing cycle frees the slot the new frame is written to.
  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && r_ready;
    push  = frame_done && (!full || pop);
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    ovr_d = ovr_q | (frame_done && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovr_q <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {frame_perr, frame_ferr, rx_sh_q};
  end

  assign {r_perr, r_ferr, r_data} = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign r_valid   = !empty;
  assign r_overrun = ovr_q;
`else
  logic                 hold_v_q, hold_v_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_perr_q, hold_perr_d;
  logic                 hold_ferr_q, hold_ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 pop;

  always_comb begin
    pop         = hold_v_q && r_ready;
    hold_v_d    = hold_v_q && !pop;
    hold_data_d = hold_data_q;
    hold_perr_d = hold_perr_q;
    hold_ferr_d = hold_ferr_q;
    ovr_d       = ovr_q;
    if (frame_done) begin
      if (!hold_v_q || pop) begin
        hold_v_d    = 1'b1;
        hold_data_d = rx_sh_q;
        hold_perr_d = frame_perr;
        hold_ferr_d = frame_ferr;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      hold_perr_q <= 1'b0;
      hold_ferr_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      hold_perr_q <= hold_perr_d;
      hold_ferr_q <= hold_ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign r_valid   = hold_v_q;
  assign r_data    = hold_data_q;
  assign r_perr    = hold_perr_q;
  assign r_ferr    = hold_ferr_q;
  assign r_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: loopback, bit-banged RX frames, overrun and reset cases.
module tb_uart_core;
  localparam int unsigned DIV = 16;
  localparam int unsigned F_A = (1 + 8 + 1 + 1) * DIV;
  localparam int unsigned F_B = (1 + 7 + 1 + 2) * DIV;
`ifdef UART_RX_FIFO_EN
  localparam int unsigned CAP = 4;
`else
  localparam int unsigned CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       loop_en, rx_drv;
  logic       rx_a, tx_a, t_valid_a, t_ready_a, r_valid_a, r_ready_a, r_perr_a, r_ferr_a, r_overrun_a;
  logic [7:0] t_data_a, r_data_a;
  logic       tx_b, t_valid_b, t_ready_b, r_valid_b, r_perr_b, r_ferr_b, r_overrun_b;
  logic [6:0] t_data_b, r_data_b;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];
  logic [8:0]  got_b[$];

  always #5 clk = ~clk;

  assign rx_a = loop_en ? tx_a : rx_drv;

  uart_core #(.DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
    .t_data(t_data_a), .t_valid(t_valid_a), .t_ready(t_ready_a),
    .r_data(r_data_a), .r_valid(r_valid_a), .r_ready(r_ready_a),
    .r_perr(r_perr_a), .r_ferr(r_ferr_a), .r_overrun(r_overrun_a)
  );

  uart_core #(.DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .rx(tx_b), .tx(tx_b),
    .t_data(t_data_b), .t_valid(t_valid_b), .t_ready(t_ready_b),
    .r_data(r_data_b), .r_valid(r_valid_b), .r_ready(1'b1),
    .r_perr(r_perr_b), .r_ferr(r_ferr_b), .r_overrun(r_overrun_b)
  );

  always @(negedge clk) begin
    if (!rst && r_valid_a && r_ready_a) got_q.push_back({r_perr_a, r_ferr_a, r_data_a});
    if (!rst && r_valid_b) got_b.push_back({r_perr_b, r_ferr_b, r_data_b});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial frame as a bit list, index 0 = first bit on the line; unused tail stays 1 (stop/idle).
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int unsigned n,
                                             input int unsigned mode);
    logic [15:0] b;
    int unsigned k, ones;
    b = '1;
    b[0] = 1'b0;
    k = 1;
    ones = 0;
    for (int unsigned i = 0; i < n; i++) begin
      b[k] = d[i];
      if (d[i]) ones++;
      k++;
    end
    if (mode == 1) b[k] = (ones % 2 == 0);
    if (mode == 2) b[k] = (ones % 2 == 1);
    return b;
  endfunction

  task automatic wait_ready_a();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!t_ready_a && n < 4 * F_A) begin
      @(negedge clk);
      n++;
    end
    check("t_ready_wait", 32'(t_ready_a), 32'd1);
  endtask

  task automatic send_a(input logic [7:0] d, input bit check_wave);
    logic [15:0] bits;
    int unsigned low;
    bits = frame_bits(d, 8, 2);
    wait_ready_a();
    @(posedge clk); #1;
    t_data_a = d;
    t_valid_a = 1'b1;
    @(posedge clk); #1;
    t_valid_a = 1'b0;
    low = 0;
    for (int unsigned n = 0; n < F_A + 8; n++) begin
      @(negedge clk);
      if (check_wave && n % DIV == DIV / 2 && n < F_A)
        check($sformatf("tx_bit%0d", n / DIV), 32'(tx_a), 32'(bits[n / DIV]));
      if (t_ready_a) break;
      low++;
    end
    if (check_wave) check("t_ready_low_cycles", low, F_A);
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [15:0] bits;
    bits = frame_bits(d, 8, 2);
    bits[9] = bits[9] ^ bad_par;
    if (bad_stop) bits[10] = 1'b0;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    exp_q.push_back({bad_par, bad_stop, d});
  endtask

  task automatic compare_rx(input string tag);
    int unsigned n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 4 * F_A) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * DIV) @(negedge clk);
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d, d0, d1, first;
    logic [15:0] bits;
    bit          bp, bs, seen_high;
    int unsigned n, low, period;

    rst = 1'b1;
    loop_en = 1'b1;
    rx_drv = 1'b1;
    t_valid_a = 1'b1;
    t_data_a = 8'hFF;
    r_ready_a = 1'b1;
    t_valid_b = 1'b0;
    t_data_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_t_ready", 32'(t_ready_a), 32'd1);
    check("rst_r_valid", 32'(r_valid_a), 32'd0);
    check("rst_r_data", 32'(r_data_a), 32'd0);
    check("rst_r_perr", 32'(r_perr_a), 32'd0);
    check("rst_r_ferr", 32'(r_ferr_a), 32'd0);
    check("rst_r_overrun", 32'(r_overrun_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    t_valid_a = 1'b0;

    send_a(8'h5A, 1'b1);
    exp_q.push_back({2'b00, 8'h5A});
    compare_rx("basic");

    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_a(d, 1'b1);
      exp_q.push_back({2'b00, d});
    end
    compare_rx("rand_loop");

    // Back-to-back: t_valid held high across two frames.
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    wait_ready_a();
    @(posedge clk); #1;
    t_data_a = d0;
    t_valid_a = 1'b1;
    @(posedge clk); #1;
    t_data_a = d1;
    seen_high = 1'b0;
    period = 0;
    for (int unsigned k = 0; k < 3 * F_A; k++) begin
      @(negedge clk);
      if (seen_high && !t_ready_a) begin
        period = k;
        break;
      end
      if (t_ready_a) seen_high = 1'b1;
    end
    t_valid_a = 1'b0;
    check("b2b_period", period, F_A + 1);
    check("b2b_second_start", 32'(tx_a), 32'd0);
    exp_q.push_back({2'b00, d0});
    exp_q.push_back({2'b00, d1});
    compare_rx("b2b");

    loop_en = 1'b0;
    drive_frame(8'hA5, 1'b1, 1'b1);
    compare_rx("err_inject");
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      bp = 1'($urandom);
      bs = 1'($urandom);
      drive_frame(d, bp, bs);
    end
    compare_rx("rand_rx");

    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    compare_rx("glitch");
    loop_en = 1'b1;
    d = 8'($urandom);
    send_a(d, 1'b0);
    exp_q.push_back({2'b00, d});
    compare_rx("after_glitch");

    @(posedge clk); #1;
    r_ready_a = 1'b0;
    first = 8'h11;
    for (int unsigned i = 0; i <= CAP; i++) begin
      d = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'($urandom);
      send_a(d, 1'b0);
      if (i < CAP) exp_q.push_back({2'b00, d});
      repeat (2 * DIV) @(negedge clk);
      if (i == CAP - 1) check("ovr_at_full", 32'(r_overrun_a), 32'd0);
    end
    check("ovr_set", 32'(r_overrun_a), 32'd1);
    check("ovr_r_valid", 32'(r_valid_a), 32'd1);
    check("ovr_head_kept", 32'(r_data_a), 32'(first));
    @(posedge clk); #1;
    r_ready_a = 1'b1;
    compare_rx("ovr_drain");
    check("ovr_sticky", 32'(r_overrun_a), 32'd1);

    // Reset during the TX DATA phase.
    wait_ready_a();
    @(posedge clk); #1;
    t_data_a = 8'h3C;
    t_valid_a = 1'b1;
    @(posedge clk); #1;
    t_valid_a = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", 32'(tx_a), 32'd1);
    check("midrst_t_ready", 32'(t_ready_a), 32'd1);
    check("midrst_r_valid", 32'(r_valid_a), 32'd0);
    check("midrst_r_overrun", 32'(r_overrun_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_a(8'hC3, 1'b1);
    exp_q.push_back({2'b00, 8'hC3});
    compare_rx("after_reset");

    // 7 data bits, odd parity, 2 stop bits.
    bits = frame_bits(8'h01, 7, 1);
    got_b.delete();
    @(posedge clk); #1;
    t_data_b = 7'h01;
    t_valid_b = 1'b1;
    @(posedge clk); #1;
    t_valid_b = 1'b0;
    low = 0;
    for (int unsigned k = 0; k < F_B + 8; k++) begin
      @(negedge clk);
      if (k % DIV == DIV / 2 && k < F_B)
        check($sformatf("b_tx_bit%0d", k / DIV), 32'(tx_b), 32'(bits[k / DIV]));
      if (t_ready_b) break;
      low++;
    end
    check("b_t_ready_low_cycles", low, F_B);
    n = 0;
    while (got_b.size() == 0 && n < F_B) begin
      @(negedge clk);
      n++;
    end
    repeat (DIV) @(negedge clk);
    check("b_rx_count", 32'(got_b.size()), 32'd1);
    if (got_b.size() > 0) check("b_rx_beat", 32'(got_b[0]), 32'({2'b00, 7'h01}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
